// File: rtl/flow_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// flow_ctrl_fsm
//   Flow-control supervisor for NUM_FIFOS FIFO channels. A threshold pair
//   (umbral_L / umbral_H) is programmed while init is low. Once init goes high
//   the block idles until a channel holds data. While ACTIVE it raises a
//   per-channel hysteretic back-pressure request (pause) from that channel's
//   occupancy count.
//
//   Optional feature macro: FLOW_CTRL_THRESH_CHECK_EN
//     When defined, leaving INIT with umbral_L_out > umbral_H_out enters ERROR.
//     ERROR can only be left by init=0 or by reset. When the macro is undefined,
//     ERROR is never entered and error_out is tied low.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   init          in   1 = configuration done, 0 = (re)configure
//   umbral_L/H    in   thresholds to program [UMBRAL_W]
//   fifo_empty    in   per-channel empty flags [NUM_FIFOS]
//   fifo_count    in   per-channel occupancy, channel i at [i*UMBRAL_W +: UMBRAL_W]
//   state         out  current state register [3]
//   nxt_state     out  combinational next state [3]
//   umbral_L/H_out out latched thresholds [UMBRAL_W]
//   idle_out      out  state == IDLE
//   active_out    out  state == ACTIVE
//   error_out     out  state == ERROR
//   pause         out  registered per-channel back-pressure [NUM_FIFOS]
// -----------------------------------------------------------------------------

// Per-channel hysteresis flop. The request is set at or above hi and cleared at
// or below lo. Between the two it holds its value. If both compares hold, set
// wins. When upd is low the flop is cleared.
module flow_ctrl_lane #(
    parameter int UMBRAL_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                upd,
    input  logic [UMBRAL_W-1:0] cnt,
    input  logic [UMBRAL_W-1:0] lo,
    input  logic [UMBRAL_W-1:0] hi,
    output logic                pause
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pause <= 1'b0;
        else if (!upd)
            pause <= 1'b0;
        else if (cnt >= hi)
            pause <= 1'b1;
        else if (cnt <= lo)
            pause <= 1'b0;
    end
endmodule

module flow_ctrl_fsm #(
    parameter int NUM_FIFOS = 8,
    parameter int UMBRAL_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [UMBRAL_W-1:0]           umbral_L,
    input  logic [UMBRAL_W-1:0]           umbral_H,
    input  logic [NUM_FIFOS-1:0]          fifo_empty,
    input  logic [NUM_FIFOS*UMBRAL_W-1:0] fifo_count,
    output logic [2:0]                    state,
    output logic [2:0]                    nxt_state,
    output logic [UMBRAL_W-1:0]           umbral_L_out,
    output logic [UMBRAL_W-1:0]           umbral_H_out,
    output logic                          idle_out,
    output logic                          active_out,
    output logic [NUM_FIFOS-1:0]          pause,
    output logic                          error_out
);
    localparam logic [2:0] S_RESET  = 3'b000;
    localparam logic [2:0] S_INIT   = 3'b001;
    localparam logic [2:0] S_IDLE   = 3'b010;
    localparam logic [2:0] S_ERROR  = 3'b011;
    localparam logic [2:0] S_ACTIVE = 3'b100;

    logic all_empty;
    logic stay_active;
    logic load_thr;

    assign all_empty   = &fifo_empty;
    // pause is only evaluated while ACTIVE persists across the edge. It
    // is cleared on the edge that leaves ACTIVE and in every other state.
    assign stay_active = (state == S_ACTIVE) && (nxt_state == S_ACTIVE);
    assign load_thr    = (state == S_INIT) && !init;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_RESET;
        else
            state <= nxt_state;
    end

    // Next-state logic
    always_comb begin
        nxt_state = S_RESET;
        case (state)
            S_RESET:  nxt_state = S_INIT;
            S_INIT: begin
                if (!init)
                    nxt_state = S_INIT;
`ifdef FLOW_CTRL_THRESH_CHECK_EN
                else if (umbral_L_out > umbral_H_out)
                    nxt_state = S_ERROR;
`endif
                else
                    nxt_state = S_IDLE;
            end
            S_IDLE:   nxt_state = !init ? S_INIT : (all_empty ? S_IDLE : S_ACTIVE);
            S_ACTIVE: nxt_state = !init ? S_INIT : (all_empty ? S_IDLE : S_ACTIVE);
            S_ERROR:  nxt_state = !init ? S_INIT : S_ERROR;
            default:  nxt_state = S_RESET;
        endcase
    end

    // Output decode, from the state register only
    always_comb begin
        idle_out   = (state == S_IDLE);
        active_out = (state == S_ACTIVE);
`ifdef FLOW_CTRL_THRESH_CHECK_EN
        error_out  = (state == S_ERROR);
`else
        error_out  = 1'b0;
`endif
    end

    // Threshold latches. They are reloaded every cycle while configuring and
    // are lost on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_L_out <= '0;
            umbral_H_out <= '0;
        end else if (load_thr) begin
            umbral_L_out <= umbral_L;
            umbral_H_out <= umbral_H;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_lane
            flow_ctrl_lane #(.UMBRAL_W(UMBRAL_W)) u_lane (
                .clk   (clk),
                .reset (reset),
                .upd   (stay_active),
                .cnt   (fifo_count[gi*UMBRAL_W +: UMBRAL_W]),
                .lo    (umbral_L_out),
                .hi    (umbral_H_out),
                .pause (pause[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_flow_ctrl_fsm
//   Self-checking bench for flow_ctrl_fsm. It runs directed scenarios first,
//   then a randomized run checked against a behavioural model.
//   The optional ERROR path is checked according to FLOW_CTRL_THRESH_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_flow_ctrl_fsm;
    localparam int NF = 8;
    localparam int W  = 8;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ERROR  = 3'd3;
    localparam logic [2:0] ST_ACTIVE = 3'd4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init = 1'b0;
    logic [W-1:0]      umbral_L = '0;
    logic [W-1:0]      umbral_H = '0;
    logic [NF-1:0]     fifo_empty = '1;
    logic [NF*W-1:0]   fifo_count = '0;
    logic [2:0]        state, nxt_state;
    logic [W-1:0]      umbral_L_out, umbral_H_out;
    logic              idle_out, active_out, error_out;
    logic [NF-1:0]     pause;

    int n_cmp = 0;
    int n_err = 0;

    flow_ctrl_fsm #(.NUM_FIFOS(NF), .UMBRAL_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_L     (umbral_L),
        .umbral_H     (umbral_H),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .state        (state),
        .nxt_state    (nxt_state),
        .umbral_L_out (umbral_L_out),
        .umbral_H_out (umbral_H_out),
        .idle_out     (idle_out),
        .active_out   (active_out),
        .pause        (pause),
        .error_out    (error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int ch, input int v);
        fifo_count[ch*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({state, umbral_L_out, umbral_H_out, pause, idle_out, active_out, error_out} !== '0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d L=%0d H=%0d pause=%h i/a/e=%b%b%b, required all 0",
                     state, umbral_L_out, umbral_H_out, pause, idle_out, active_out, error_out);
        end
        tick();
        n_cmp++;
        if (state !== ST_RESET) begin
            n_err++;
            $display("FAIL reset_hold: state=%0d required 0", state);
        end
    endtask

    task automatic test_config();
        init = 1'b0; umbral_L = 8'd2; umbral_H = 8'd6; fifo_empty = '1;
        @(negedge clk); reset = 1'b0;
        tick();
        n_cmp++;
        if (state !== ST_INIT) begin
            n_err++;
            $display("FAIL cfg_to_init: state=%0d required %0d", state, ST_INIT);
        end
        tick(); tick();
        n_cmp++;
        if (umbral_L_out !== 8'd2 || umbral_H_out !== 8'd6) begin
            n_err++;
            $display("FAIL cfg_load: L=%0d H=%0d required 2 6", umbral_L_out, umbral_H_out);
        end
        init = 1'b1; umbral_L = 8'd9; umbral_H = 8'd1;
        tick();
        n_cmp++;
        if (state !== ST_IDLE || idle_out !== 1'b1 || umbral_L_out !== 8'd2 || umbral_H_out !== 8'd6) begin
            n_err++;
            $display("FAIL cfg_to_idle: state=%0d idle=%b L=%0d H=%0d required 2 1 2 6",
                     state, idle_out, umbral_L_out, umbral_H_out);
        end
    endtask

    task automatic test_idle_active();
        fifo_empty = 8'hFE;
        tick();
        n_cmp++;
        if (state !== ST_ACTIVE || active_out !== 1'b1 || idle_out !== 1'b0) begin
            n_err++;
            $display("FAIL idle_to_active: state=%0d active=%b idle=%b required 4 1 0", state, active_out, idle_out);
        end
        fifo_empty = 8'hFF;
        tick();
        n_cmp++;
        if (state !== ST_IDLE || idle_out !== 1'b1 || active_out !== 1'b0) begin
            n_err++;
            $display("FAIL active_to_idle: state=%0d idle=%b active=%b required 2 1 0", state, idle_out, active_out);
        end
    endtask

    task automatic test_pause();
        int cnts[5] = '{5, 6, 4, 2, 1};
        bit exp[5]  = '{0, 1, 1, 0, 0};
        fifo_empty = 8'hFE;
        fifo_count = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            set_cnt(3, cnts[k]);
            n_cmp++;
            if (pause[3] !== (k == 0 ? 1'b0 : exp[k-1])) begin
                n_err++;
                $display("FAIL pause_latency k=%0d: pause3=%b changed before the edge", k, pause[3]);
            end
            tick();
            n_cmp++;
            if (pause !== (NF'(exp[k]) << 3)) begin
                n_err++;
                $display("FAIL pause_seq k=%0d cnt=%0d: pause=%h required %h", k, cnts[k], pause, NF'(exp[k]) << 3);
            end
        end
    endtask

    task automatic test_reinit();
        set_cnt(3, 6);
        tick();
        n_cmp++;
        if (pause[3] !== 1'b1) begin
            n_err++;
            $display("FAIL reinit_pre: pause3=%b required 1", pause[3]);
        end
        init = 1'b0; umbral_L = 8'd1; umbral_H = 8'd9;
        tick();
        n_cmp++;
        if (state !== ST_INIT || pause !== '0 || umbral_L_out !== 8'd2) begin
            n_err++;
            $display("FAIL reinit_enter: state=%0d pause=%h L=%0d required 1 00 2", state, pause, umbral_L_out);
        end
        tick();
        n_cmp++;
        if (umbral_L_out !== 8'd1 || umbral_H_out !== 8'd9) begin
            n_err++;
            $display("FAIL reinit_load: L=%0d H=%0d required 1 9", umbral_L_out, umbral_H_out);
        end
    endtask

    task automatic test_thresh_check();
        fifo_empty = 8'hFF;
        umbral_L = 8'd7; umbral_H = 8'd3;
        tick();
        init = 1'b1;
        tick();
`ifdef FLOW_CTRL_THRESH_CHECK_EN
        n_cmp++;
        if (state !== ST_ERROR || error_out !== 1'b1) begin
            n_err++;
            $display("FAIL thr_error: state=%0d err=%b required 3 1", state, error_out);
        end
        fifo_empty = 8'h00;
        set_cnt(0, 200);
        tick();
        n_cmp++;
        if (state !== ST_ERROR || pause !== '0) begin
            n_err++;
            $display("FAIL thr_error_hold: state=%0d pause=%h required 3 00", state, pause);
        end
        fifo_empty = 8'hFF;
`else
        n_cmp++;
        if (state !== ST_IDLE || error_out !== 1'b0) begin
            n_err++;
            $display("FAIL thr_nocheck: state=%0d err=%b required 2 0", state, error_out);
        end
`endif
        init = 1'b0; umbral_L = 8'd2; umbral_H = 8'd6;
        tick();
        n_cmp++;
        if (state !== ST_INIT || error_out !== 1'b0) begin
            n_err++;
            $display("FAIL thr_leave: state=%0d err=%b required 1 0", state, error_out);
        end
        tick();
        init = 1'b1;
        tick();
        n_cmp++;
        if (state !== ST_IDLE) begin
            n_err++;
            $display("FAIL thr_idle: state=%0d required 2", state);
        end
    endtask

    task automatic test_async_reset();
        fifo_count = '0;
        fifo_empty = 8'hFE;
        tick();
        set_cnt(3, 9);
        tick();
        n_cmp++;
        if (state !== ST_ACTIVE || pause[3] !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: state=%0d pause3=%b required 4 1", state, pause[3]);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({state, umbral_L_out, umbral_H_out, pause, idle_out, active_out, error_out} !== '0) begin
            n_err++;
            $display("FAIL areset_async: state=%0d L=%0d H=%0d pause=%h i/a/e=%b%b%b required all 0",
                     state, umbral_L_out, umbral_H_out, pause, idle_out, active_out, error_out);
        end
        @(negedge clk);
    endtask

    // Behavioural model: one step of the controller, derived from the
    // published rules (state codes are the externally visible encoding).
    task automatic test_random();
        logic [2:0]    m_st = ST_RESET;
        logic [W-1:0]  m_L = '0, m_H = '0;
        logic [NF-1:0] m_p = '0;
        logic [2:0]    n_st;
        logic [W-1:0]  n_L, n_H;
        logic [NF-1:0] n_p;
        int            c[NF];
        reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset      = ($urandom_range(0, 63) == 0);
            init       = ($urandom_range(0, 7) != 0);
            umbral_L   = W'($urandom_range(0, 15));
            umbral_H   = W'($urandom_range(0, 15));
            fifo_empty = ($urandom_range(0, 1) == 0) ? '1 : NF'($urandom);
            for (int i = 0; i < NF; i++) begin
                c[i] = $urandom_range(0, 15);
                set_cnt(i, c[i]);
            end
            n_st = m_st; n_L = m_L; n_H = m_H; n_p = '0;
            if (reset) begin
                n_st = ST_RESET; n_L = '0; n_H = '0;
            end else if (m_st == ST_RESET) begin
                n_st = ST_INIT;
            end else if (m_st == ST_INIT) begin
                if (!init) begin
                    n_L = umbral_L; n_H = umbral_H;
                end
`ifdef FLOW_CTRL_THRESH_CHECK_EN
                else if (m_L > m_H) n_st = ST_ERROR;
`endif
                else n_st = ST_IDLE;
            end else if (!init) begin
                n_st = ST_INIT;
            end else if (m_st == ST_IDLE || m_st == ST_ACTIVE) begin
                n_st = (fifo_empty == '1) ? ST_IDLE : ST_ACTIVE;
            end
            if (!reset && m_st == ST_ACTIVE && n_st == ST_ACTIVE)
                for (int i = 0; i < NF; i++)
                    n_p[i] = (c[i] >= int'(m_H)) ? 1'b1 : (c[i] <= int'(m_L)) ? 1'b0 : m_p[i];
            #1;
            if (!reset) begin
                n_cmp++;
                if (nxt_state !== n_st) begin
                    n_err++;
                    $display("FAIL rnd_nxt cyc=%0d: nxt_state=%0d required %0d", cyc, nxt_state, n_st);
                end
            end
            tick();
            m_st = n_st; m_L = n_L; m_H = n_H; m_p = n_p;
            n_cmp++;
            if (state !== m_st || umbral_L_out !== m_L || umbral_H_out !== m_H || pause !== m_p ||
                idle_out !== (m_st == ST_IDLE) || active_out !== (m_st == ST_ACTIVE) ||
                error_out !== (m_st == ST_ERROR)) begin
                n_err++;
                $display("FAIL rnd cyc=%0d: st=%0d L=%0d H=%0d p=%h iae=%b%b%b required st=%0d L=%0d H=%0d p=%h",
                         cyc, state, umbral_L_out, umbral_H_out, pause, idle_out, active_out, error_out,
                         m_st, m_L, m_H, m_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_idle_active();
        test_pause();
        test_reinit();
        test_thresh_check();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/flow_ctrl_fsm.md
FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 8: number of monitored FIFO channels (legal range 1..32).
REQ-002 SHALL have parameter UMBRAL_W, default 8: width of each threshold and of each per-channel occupancy count.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port init, input, 1: high = configuration done; low = (re)configure.
REQ-006 SHALL have port umbral_L, input, UMBRAL_W: low threshold to program.
REQ-007 SHALL have port umbral_H, input, UMBRAL_W: high threshold to program.
REQ-008 SHALL have port fifo_empty, input, NUM_FIFOS: per-channel empty flags; bit i = channel i.
REQ-009 SHALL have port fifo_count, input, NUM_FIFOS*UMBRAL_W: per-channel occupancy; channel i in bits [i*UMBRAL_W +: UMBRAL_W].
REQ-010 SHALL have port state, output, 3: current state register.
REQ-011 SHALL have port nxt_state, output, 3: combinational next state.
REQ-012 SHALL have port umbral_L_out, output, UMBRAL_W: latched low threshold.
REQ-013 SHALL have port umbral_H_out, output, UMBRAL_W: latched high threshold.
REQ-014 SHALL have port idle_out, output, 1: high exactly while state == IDLE.
REQ-015 SHALL have port active_out, output, 1: high exactly while state == ACTIVE.
REQ-016 SHALL have port pause, output, NUM_FIFOS: registered per-channel back-pressure request.
REQ-017 SHALL have port error_out, output, 1: high exactly while state == ERROR.

Function
REQ-018 SHALL encode states as RESET=3'b000, INIT=3'b001, IDLE=3'b010, ERROR=3'b011, ACTIVE=3'b100; any other value SHALL go to RESET next cycle.
REQ-019 RESET SHALL go to INIT on the first clock edge with reset low.
REQ-020 INIT with init=0 SHALL load umbral_L/umbral_H into umbral_L_out/umbral_H_out every cycle and stay in INIT.
REQ-021 INIT with init=1 SHALL go to IDLE without loading thresholds that cycle.
REQ-022 IDLE SHALL go to ACTIVE when any fifo_empty bit is 0, else stay IDLE.
REQ-023 ACTIVE SHALL go to IDLE when fifo_empty is all ones, else stay ACTIVE.
REQ-024 In IDLE, ACTIVE and ERROR, init=0 SHALL take priority over all other conditions and go to INIT.
REQ-025 Thresholds SHALL hold their value outside INIT.
REQ-026 In ACTIVE, pause[i] SHALL be set when count_i >= umbral_H_out, cleared when count_i <= umbral_L_out, else held; unsigned compares, set wins if both hold.
REQ-027 pause SHALL be forced to 0 on the edge that leaves ACTIVE and in every non-ACTIVE state.
REQ-028 pause SHALL have one-cycle latency from fifo_count to output.
REQ-029 idle_out, active_out and error_out SHALL be decoded from the state register only: glitch-free, no latches.

Reset
REQ-030 reset high SHALL immediately force state=RESET, umbral_L_out=0, umbral_H_out=0, pause=0, idle_out=0, active_out=0, error_out=0, independent of clk.
REQ-031 reset asserted mid-operation in any state SHALL abort it; thresholds SHALL be lost and reprogramming through INIT SHALL be required.

Configuration
REQ-032 With macro FLOW_CTRL_THRESH_CHECK_EN defined, INIT with init=1 and umbral_L_out > umbral_H_out SHALL go to ERROR instead of IDLE; ERROR SHALL hold pause=0 and leave only via init=0 or reset.
REQ-033 Without FLOW_CTRL_THRESH_CHECK_EN, ERROR SHALL be unreachable, error_out SHALL be tied to 0, and INIT with init=1 SHALL always go to IDLE.

Verification
REQ-034 reset=1 then 0, init=0, umbral_L=2, umbral_H=6 for 3 cycles, then init=1 -> RESET, INIT, IDLE in that order; umbral_L_out=2, umbral_H_out=6; idle_out=1.
REQ-035 In IDLE, fifo_empty=8'hFE -> ACTIVE next edge with active_out=1; fifo_empty=8'hFF -> back to IDLE.
REQ-036 In ACTIVE, ch3 count 5,6,4,2,1 with L=2, H=6 -> pause[3] = 0,1,1,0,0, each one cycle after its count.
REQ-037 With pause[3]=1, set init=0 -> INIT next edge, pause cleared, new thresholds loaded.
REQ-038 With FLOW_CTRL_THRESH_CHECK_EN: L=7, H=3, init=1 -> ERROR, error_out=1; without the macro -> IDLE.
REQ-039 reset pulse between clock edges while in ACTIVE -> state=0 and all outputs 0 before the next clk edge.
